axi_10g_ethernet_0_user_checker: RTL and testbench
==================================================

AXI_10G_ETHERNET_0_USER_CHECKER -- requirements
Module: axi_10g_ethernet_0_user_checker

Interface
REQ-001 SHALL provide parameter READY_PATTERN, default 8'hFF, rotating tready enable mask; bit 0 is used first.
REQ-002 SHALL provide parameter SYNC_ON_FIRST, default 1'b0; when 1, the first accepted beat seeds the expected value instead of 0.
REQ-003 SHALL provide parameter TARGET_BEATS, default 32'd100000, the beat count at which the done output asserts.
REQ-004 s_aclk  input  1  sole clock; all logic is rising-edge.
REQ-005 s_aresetn  input  1  reset, synchronous, active-low.
REQ-006 rx_axis_tvalid  input  1  receive-stream data valid from TCP core.
REQ-007 rx_axis_tready  output  1  checker ready to accept a beat.
REQ-008 rx_axis_tdata  input  64  received payload word.
REQ-009 rx_axis_tkeep  input  8  byte enables; only 8'hFF beats are data-checked.
REQ-010 tcp_state_out  input  4  TCP connection state; 4'b0011 = ESTABLISHED.
REQ-011 err_clear  input  1  single-cycle pulse clearing error_count and error_flag.
REQ-012 beat_count  output  32  accepted full beats since reset, wraps at 2^32.
REQ-013 error_count  output  16  mismatch plus partial-keep events, saturates at 16'hFFFF.
REQ-014 error_flag  output  1  sticky, set on any error event.
REQ-015 first_err_data  output  64  tdata of the first error beat since the last reset or clear.
REQ-016 done  output  1  level, high once beat_count >= TARGET_BEATS with error_count == 0.

Function
REQ-017 A beat SHALL be accepted only on a cycle where rx_axis_tvalid and rx_axis_tready are both 1.
REQ-018 The FSM SHALL have states IDLE, SYNC and CHECK.
REQ-019 IDLE: rx_axis_tready = 0; the FSM moves to SYNC when tcp_state_out == 4'b0011.
REQ-020 SYNC: on the first accepted full beat the FSM moves to CHECK.
  - SYNC_ON_FIRST=1: expected <= tdata+1 and no comparison is made.
  - SYNC_ON_FIRST=0: the beat is compared against 0.
REQ-021 CHECK: each accepted full beat SHALL be compared with expected.
  - Match: expected <= expected+1.
  - Mismatch: error event, and expected <= tdata+1 (resync).
REQ-022 An accepted beat with tkeep != 8'hFF SHALL be an error event; expected is not advanced and beat_count is not incremented.
REQ-023 From SYNC or CHECK, tcp_state_out != 4'b0011 SHALL force IDLE the next cycle.
  - tready drops that same next cycle.
  - Counters, flags and expected are retained.
  - Re-entry goes through SYNC.
REQ-024 In SYNC/CHECK, rx_axis_tready SHALL equal the current bit 0 of a registered rotating copy of READY_PATTERN; the copy rotates right by one every cycle in any state.
REQ-025 beat_count, error_count, error_flag and first_err_data SHALL update on the clock edge following the accepting cycle (1-cycle latency).
REQ-026 first_err_data SHALL capture only when error_flag is 0 prior to the event.
REQ-027 err_clear with a simultaneous error event: the event wins (error_count=1, error_flag=1, first_err_data captured).
REQ-028 error_count at 16'hFFFF SHALL hold; beat_count at 32'hFFFFFFFF SHALL wrap to 0.
REQ-029 expected SHALL be 64-bit and wrap from all-ones to 0 without error.
REQ-030 done SHALL be registered and recomputed every cycle; it deasserts if a later error occurs.

Reset
REQ-031 On a clock edge with s_aresetn=0, the following SHALL take these values:
  - FSM: IDLE
  - rx_axis_tready: 0
  - expected: 0
  - beat_count, error_count: 0
  - error_flag, done: 0
  - first_err_data: 0
  - rotating pattern: READY_PATTERN
REQ-032 Reset mid-transfer SHALL discard the in-flight beat; it is neither counted nor checked.

Verification
REQ-033 Established, tvalid=1, tdata 0,1,2,...,99, tkeep=FF, TARGET_BEATS=100 -> beat_count=100, error_count=0, done=1 one cycle after the last beat.
REQ-034 Sequence 0,1,2,7,8 -> error_count=1, first_err_data=7, no further errors (resync to 8), beat_count=5.
REQ-035 READY_PATTERN=8'b0101_0101, continuous tvalid -> tready alternates 1/0; 10 beats accepted in 20 cycles with no loss or duplication.
REQ-036 tcp_state_out drops to 4'b0001 after beat 5, returns later -> tready=0 while away; with SYNC_ON_FIRST=0 the next beat 5 mismatches against 0 (error_count=1); with SYNC_ON_FIRST=1 there is no error.
REQ-037 Beat with tkeep=8'h0F, then err_clear coinciding with a mismatch beat -> error_count=1 after the clear cycle, error_flag=1, first_err_data = the mismatch tdata.
REQ-038 s_aresetn=0 asserted mid-stream for one cycle -> all outputs at reset values the next cycle; the FSM re-enters SYNC.

Source files
------------

// File: rtl/axi_10g_ethernet_0_user_checker.sv
`default_nettype none
// ============================================================================
//  Module      : axi_10g_ethernet_0_user_checker
//  Description : Receive-side AXI-Stream checker for the 10G TCP example.
//                Accepts 64-bit beats while the connection is ESTABLISHED and
//                checks them against an incrementing 64-bit sequence. It counts
//                beats and errors, and flags completion once enough clean
//                beats have arrived.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_10g_ethernet_0_user_checker #(
  parameter logic [7:0]  READY_PATTERN = 8'hFF,
  parameter logic        SYNC_ON_FIRST = 1'b0,
  parameter logic [31:0] TARGET_BEATS  = 32'd100000
) (
  input  logic        s_aclk,
  input  logic        s_aresetn,
  input  logic        rx_axis_tvalid,
  output logic        rx_axis_tready,
  input  logic [63:0] rx_axis_tdata,
  input  logic [7:0]  rx_axis_tkeep,
  input  logic [3:0]  tcp_state_out,
  input  logic        err_clear,
  output logic [31:0] beat_count,
  output logic [15:0] error_count,
  output logic        error_flag,
  output logic [63:0] first_err_data,
  output logic        done
);

  localparam logic [3:0]  TCP_ESTABLISHED = 4'b0011;
  localparam logic [15:0] ERR_MAX         = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  ready_rot;
  logic [63:0] expected;

  logic        established;
  logic        accept;
  logic        full_beat;
  logic        full_accept;
  logic        seed_only;
  logic        mismatch;
  logic        err_event;
  logic [63:0] compare_value;
  logic [31:0] beat_count_next;
  logic [15:0] error_count_next;
  logic        error_flag_next;
  logic [63:0] first_err_next;
  logic        done_next;

  assign established    = (tcp_state_out == TCP_ESTABLISHED);
  assign rx_axis_tready = (state != IDLE) && ready_rot[0];
  assign accept         = rx_axis_tvalid && rx_axis_tready;
  assign full_beat      = (rx_axis_tkeep == 8'hFF);
  assign full_accept    = accept && full_beat;

  // State register and free-running rotation of the ready mask
  always_ff @(posedge s_aclk) begin
    if (!s_aresetn) begin
      state     <= IDLE;
      ready_rot <= READY_PATTERN;
    end else begin
      state     <= state_next;
      ready_rot <= {ready_rot[0], ready_rot[7:1]};
    end
  end

  // Next-state logic: losing the connection always returns to IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (established) state_next = SYNC;
      SYNC: begin
        if (!established)     state_next = IDLE;
        else if (full_accept) state_next = CHECK;
      end
      CHECK:   if (!established) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Compare, error and counter next values; an error event beats err_clear
  always_comb begin
    seed_only        = (state == SYNC) && SYNC_ON_FIRST;
    compare_value    = (state == SYNC) ? 64'd0 : expected;
    mismatch         = full_accept && !seed_only && (rx_axis_tdata != compare_value);
    err_event        = (accept && !full_beat) || mismatch;
    beat_count_next  = beat_count + {31'd0, full_accept};
    error_count_next = error_count;
    error_flag_next  = error_flag;
    first_err_next   = first_err_data;
    if (err_event) begin
      if (err_clear)                 error_count_next = 16'd1;
      else if (error_count != ERR_MAX) error_count_next = error_count + 16'd1;
      error_flag_next = 1'b1;
      if (!error_flag || err_clear) first_err_next = rx_axis_tdata;
    end else if (err_clear) begin
      error_count_next = 16'd0;
      error_flag_next  = 1'b0;
      first_err_next   = 64'd0;
    end
    done_next = (beat_count_next >= TARGET_BEATS) && (error_count_next == 16'd0);
  end

  // Datapath registers; expected follows the last full beat (match or resync)
  always_ff @(posedge s_aclk) begin
    if (!s_aresetn) begin
      expected       <= 64'd0;
      beat_count     <= 32'd0;
      error_count    <= 16'd0;
      error_flag     <= 1'b0;
      first_err_data <= 64'd0;
      done           <= 1'b0;
    end else begin
      if (full_accept) expected <= rx_axis_tdata + 64'd1;
      beat_count     <= beat_count_next;
      error_count    <= error_count_next;
      error_flag     <= error_flag_next;
      first_err_data <= first_err_next;
      done           <= done_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_10g_ethernet_0_user_checker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_axi_10g_ethernet_0_user_checker
//  Description : Self-checking bench; three checker instances share stimulus
//                and are compared every cycle against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_10g_ethernet_0_user_checker;

  localparam int          N      = 3;
  localparam logic [31:0] TARGET = 32'd100;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        tvalid = 1'b0;
  logic [63:0] tdata = 64'd0;
  logic [7:0]  tkeep = 8'hFF;
  logic [3:0]  tcp = 4'd0;
  logic        err_clear = 1'b0;

  logic        tready_o [N];
  logic [31:0] beat_o   [N];
  logic [15:0] ecnt_o   [N];
  logic        flag_o   [N];
  logic [63:0] first_o  [N];
  logic        done_o   [N];

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  // model state
  bit          m_active [N];
  bit          m_synced [N];
  logic [63:0] m_exp    [N];
  logic [31:0] m_beat   [N];
  int          m_ecnt   [N];
  bit          m_flag   [N];
  logic [63:0] m_first  [N];
  bit          m_done   [N];
  int          m_cyc = 0;

  always #5 clk = ~clk;

  axi_10g_ethernet_0_user_checker #(.READY_PATTERN(8'hFF), .SYNC_ON_FIRST(1'b0), .TARGET_BEATS(TARGET)) dut0 (
    .s_aclk(clk), .s_aresetn(rstn), .rx_axis_tvalid(tvalid), .rx_axis_tready(tready_o[0]),
    .rx_axis_tdata(tdata), .rx_axis_tkeep(tkeep), .tcp_state_out(tcp), .err_clear(err_clear),
    .beat_count(beat_o[0]), .error_count(ecnt_o[0]), .error_flag(flag_o[0]),
    .first_err_data(first_o[0]), .done(done_o[0]));

  axi_10g_ethernet_0_user_checker #(.READY_PATTERN(8'hFF), .SYNC_ON_FIRST(1'b1), .TARGET_BEATS(TARGET)) dut1 (
    .s_aclk(clk), .s_aresetn(rstn), .rx_axis_tvalid(tvalid), .rx_axis_tready(tready_o[1]),
    .rx_axis_tdata(tdata), .rx_axis_tkeep(tkeep), .tcp_state_out(tcp), .err_clear(err_clear),
    .beat_count(beat_o[1]), .error_count(ecnt_o[1]), .error_flag(flag_o[1]),
    .first_err_data(first_o[1]), .done(done_o[1]));

  axi_10g_ethernet_0_user_checker #(.READY_PATTERN(8'h55), .SYNC_ON_FIRST(1'b1), .TARGET_BEATS(TARGET)) dut2 (
    .s_aclk(clk), .s_aresetn(rstn), .rx_axis_tvalid(tvalid), .rx_axis_tready(tready_o[2]),
    .rx_axis_tdata(tdata), .rx_axis_tkeep(tkeep), .tcp_state_out(tcp), .err_clear(err_clear),
    .beat_count(beat_o[2]), .error_count(ecnt_o[2]), .error_flag(flag_o[2]),
    .first_err_data(first_o[2]), .done(done_o[2]));

  function automatic logic [7:0] pat_of(input int k);
    return (k == 2) ? 8'h55 : 8'hFF;
  endfunction

  function automatic bit sof_of(input int k);
    return (k != 0);
  endfunction

  // ready in the current cycle: connection up and mask bit for cycles since reset
  function automatic bit m_rdy(input int k);
    logic [7:0] p;
    logic [2:0] idx;
    p   = pat_of(k);
    idx = 3'(m_cyc);
    return m_active[k] && p[idx];
  endfunction

  task automatic check(input int k, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL inst%0d %s actual=%h expected=%h t=%0t", k, nm, act, exp, $time);
    end
  endtask

  // pins both the DUT and the model to a hand-computed value
  task automatic pin(input int k, input string nm, input logic [63:0] dutv, input logic [63:0] modv, input logic [63:0] lit);
    check(k, nm, dutv, lit);
    check(k, {"model ", nm}, modv, lit);
  endtask

  task automatic model_step(input int k);
    bit          rdy, acc, full, err;
    logic [63:0] refv;
    if (!rstn) begin
      m_active[k] = 0; m_synced[k] = 0; m_exp[k] = '0; m_beat[k] = '0;
      m_ecnt[k] = 0; m_flag[k] = 0; m_first[k] = '0; m_done[k] = 0;
      return;
    end
    rdy  = m_rdy(k);
    acc  = tvalid && rdy;
    full = (tkeep == 8'hFF);
    err  = acc && !full;
    if (acc && full) begin
      m_beat[k] = m_beat[k] + 32'd1;
      if (m_synced[k] || !sof_of(k)) begin
        refv = m_synced[k] ? m_exp[k] : 64'd0;
        if (tdata != refv) err = 1;
      end
      m_exp[k]    = tdata + 64'd1;
      m_synced[k] = 1;
    end
    if (err) begin
      if (!m_flag[k] || err_clear) m_first[k] = tdata;
      m_ecnt[k] = err_clear ? 1 : ((m_ecnt[k] < 65535) ? m_ecnt[k] + 1 : 65535);
      m_flag[k] = 1;
    end else if (err_clear) begin
      m_ecnt[k] = 0; m_flag[k] = 0; m_first[k] = '0;
    end
    m_done[k] = (m_beat[k] >= TARGET) && (m_ecnt[k] == 0);
    if (!m_active[k]) begin
      if (tcp == 4'b0011) begin m_active[k] = 1; m_synced[k] = 0; end
    end else if (tcp != 4'b0011) begin
      m_active[k] = 0;
    end
  endtask

  // model advance on every rising edge
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) model_step(k);
    m_cyc = rstn ? m_cyc + 1 : 0;
  end

  // compare every instance against the model on every falling edge
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < N; k++) begin
        check(k, "tready",         64'(tready_o[k]), 64'(m_rdy(k)));
        check(k, "beat_count",     64'(beat_o[k]),   64'(m_beat[k]));
        check(k, "error_count",    64'(ecnt_o[k]),   64'(m_ecnt[k]));
        check(k, "error_flag",     64'(flag_o[k]),   64'(m_flag[k]));
        check(k, "first_err_data", first_o[k],       m_first[k]);
        check(k, "done",           64'(done_o[k]),   64'(m_done[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic beat(input logic [63:0] d, input logic [7:0] kp);
    tvalid = 1'b1; tdata = d; tkeep = kp;
    tick();
    tvalid = 1'b0; tkeep = 8'hFF;
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rstn = 1'b0; tvalid = 1'b0; err_clear = 1'b0; tkeep = 8'hFF;
    tick(); tick();
    rstn = 1'b1;
  endtask

  task automatic pin_zero(input int k, input string nm);
    pin(k, {nm, " beat"},  64'(beat_o[k]),   64'(m_beat[k]),  64'd0);
    pin(k, {nm, " ecnt"},  64'(ecnt_o[k]),   64'(m_ecnt[k]),  64'd0);
    pin(k, {nm, " flag"},  64'(flag_o[k]),   64'(m_flag[k]),  64'd0);
    pin(k, {nm, " first"}, first_o[k],       m_first[k],      64'd0);
    pin(k, {nm, " done"},  64'(done_o[k]),   64'(m_done[k]),  64'd0);
    check(k, {nm, " tready"}, 64'(tready_o[k]), 64'd0);
  endtask

  initial begin
    logic [63:0] d;
    logic [63:0] sd;
    bit          acc;
    int          r;

    // reset state
    tcp = 4'b0011;
    do_reset();
    started = 1'b1;
    for (int k = 0; k < N; k++) pin_zero(k, "reset");

    // 100 sequential beats reach done one cycle after the last beat
    idle(1);
    for (int i = 0; i < 99; i++) beat(64'(i), 8'hFF);
    pin(0, "pre-done beat", 64'(beat_o[0]), 64'(m_beat[0]), 64'd99);
    pin(0, "pre-done done", 64'(done_o[0]), 64'(m_done[0]), 64'd0);
    beat(64'd99, 8'hFF);
    for (int k = 0; k < 2; k++) begin
      pin(k, "seq beat", 64'(beat_o[k]), 64'(m_beat[k]), 64'd100);
      pin(k, "seq ecnt", 64'(ecnt_o[k]), 64'(m_ecnt[k]), 64'd0);
      pin(k, "seq done", 64'(done_o[k]), 64'(m_done[k]), 64'd1);
    end
    beat(64'd5, 8'hFF);
    pin(0, "late err done", 64'(done_o[0]), 64'(m_done[0]), 64'd0);
    pin(0, "late err ecnt", 64'(ecnt_o[0]), 64'(m_ecnt[0]), 64'd1);

    // 0,1,2,7,8: one error, resync to 8
    do_reset();
    idle(1);
    beat(64'd0, 8'hFF); beat(64'd1, 8'hFF); beat(64'd2, 8'hFF); beat(64'd7, 8'hFF); beat(64'd8, 8'hFF);
    idle(1);
    for (int k = 0; k < 2; k++) begin
      pin(k, "resync ecnt",  64'(ecnt_o[k]), 64'(m_ecnt[k]), 64'd1);
      pin(k, "resync first", first_o[k],     m_first[k],     64'd7);
      pin(k, "resync beat",  64'(beat_o[k]), 64'(m_beat[k]), 64'd5);
    end

    // alternating ready on instance 2: handshake driven from its tready
    do_reset();
    d = 64'd0; tvalid = 1'b1; tdata = d;
    tick();
    for (int i = 0; i < 20; i++) begin
      if (i < 4) check(2, "tready alt", 64'(tready_o[2]), 64'(i % 2));
      acc = tvalid && tready_o[2];
      tick();
      if (acc) d = d + 64'd1;
      tdata = d;
    end
    tvalid = 1'b0;
    pin(2, "alt beat", 64'(beat_o[2]), 64'(m_beat[2]), 64'd10);
    pin(2, "alt ecnt", 64'(ecnt_o[2]), 64'(m_ecnt[2]), 64'd0);
    idle(1);

    // connection drop after beat 5 and re-entry through SYNC
    do_reset();
    idle(1);
    for (int i = 0; i < 5; i++) beat(64'(i), 8'hFF);
    tcp = 4'b0001;
    tick();
    for (int i = 0; i < 3; i++) begin
      tvalid = 1'b1; tdata = 64'd77;
      check(0, "tready away", 64'(tready_o[0]), 64'd0);
      check(1, "tready away", 64'(tready_o[1]), 64'd0);
      tick();
    end
    tvalid = 1'b0; tcp = 4'b0011;
    tick(); tick();
    beat(64'd5, 8'hFF);
    pin(0, "rejoin ecnt",  64'(ecnt_o[0]), 64'(m_ecnt[0]), 64'd1);
    pin(0, "rejoin first", first_o[0],     m_first[0],     64'd5);
    pin(1, "rejoin ecnt",  64'(ecnt_o[1]), 64'(m_ecnt[1]), 64'd0);
    pin(1, "rejoin beat",  64'(beat_o[1]), 64'(m_beat[1]), 64'd6);

    // partial keep, then err_clear coinciding with a mismatch
    do_reset();
    idle(1);
    beat(64'd0, 8'hFF); beat(64'd1, 8'hFF); beat(64'd2, 8'h0F);
    pin(0, "partial ecnt",  64'(ecnt_o[0]), 64'(m_ecnt[0]), 64'd1);
    pin(0, "partial beat",  64'(beat_o[0]), 64'(m_beat[0]), 64'd2);
    pin(0, "partial first", first_o[0],     m_first[0],     64'd2);
    beat(64'd2, 8'hFF);
    err_clear = 1'b1;
    beat(64'd99, 8'hFF);
    err_clear = 1'b0;
    pin(0, "clr+err ecnt",  64'(ecnt_o[0]), 64'(m_ecnt[0]), 64'd1);
    pin(0, "clr+err flag",  64'(flag_o[0]), 64'(m_flag[0]), 64'd1);
    pin(0, "clr+err first", first_o[0],     m_first[0],     64'd99);
    pin(0, "clr+err beat",  64'(beat_o[0]), 64'(m_beat[0]), 64'd4);
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    pin(0, "clear ecnt", 64'(ecnt_o[0]), 64'(m_ecnt[0]), 64'd0);
    pin(0, "clear flag", 64'(flag_o[0]), 64'(m_flag[0]), 64'd0);

    // one-cycle reset mid-stream discards the in-flight beat
    do_reset();
    idle(1);
    for (int i = 0; i < 4; i++) beat(64'(i), 8'hFF);
    rstn = 1'b0; tvalid = 1'b1; tdata = 64'd4;
    tick();
    rstn = 1'b1; tvalid = 1'b0;
    for (int k = 0; k < 2; k++) pin_zero(k, "midreset");
    tick();
    beat(64'd0, 8'hFF); beat(64'd1, 8'hFF); beat(64'd2, 8'hFF);
    pin(0, "post-reset beat", 64'(beat_o[0]), 64'(m_beat[0]), 64'd3);
    pin(0, "post-reset ecnt", 64'(ecnt_o[0]), 64'(m_ecnt[0]), 64'd0);

    // 64-bit expected wrap
    do_reset();
    idle(1);
    beat(64'hFFFF_FFFF_FFFF_FFFE, 8'hFF); beat(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    beat(64'd0, 8'hFF); beat(64'd1, 8'hFF);
    pin(1, "wrap ecnt", 64'(ecnt_o[1]), 64'(m_ecnt[1]), 64'd0);
    pin(1, "wrap beat", 64'(beat_o[1]), 64'(m_beat[1]), 64'd4);
    pin(0, "wrap ecnt", 64'(ecnt_o[0]), 64'(m_ecnt[0]), 64'd1);

    // randomized traffic
    do_reset();
    sd = 64'd0;
    for (int i = 0; i < 3000; i++) begin
      rstn      = ($urandom_range(0, 499) != 0);
      tcp       = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(0, 15)) : 4'b0011;
      tvalid    = ($urandom_range(0, 3) != 0);
      tkeep     = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'hFF;
      err_clear = ($urandom_range(0, 49) == 0);
      r = $urandom_range(0, 29);
      if (r == 0)      sd = {32'($urandom), 32'($urandom)};
      else if (r == 1) sd = 64'hFFFF_FFFF_FFFF_FFFE;
      else if (r < 20) sd = sd + 64'd1;
      tdata = sd;
      tick();
    end
    rstn = 1'b1; err_clear = 1'b0; tcp = 4'b0011;

    // error counter saturation with continuous partial beats
    do_reset();
    idle(1);
    tvalid = 1'b1; tkeep = 8'h0F;
    for (int i = 0; i < 65540; i++) begin
      tdata = 64'hABCD_0000 + 64'(i);
      tick();
    end
    tvalid = 1'b0; tkeep = 8'hFF;
    pin(0, "sat ecnt",  64'(ecnt_o[0]), 64'(m_ecnt[0]), 64'hFFFF);
    pin(0, "sat flag",  64'(flag_o[0]), 64'(m_flag[0]), 64'd1);
    pin(0, "sat first", first_o[0],     m_first[0],     64'hABCD_0000);
    pin(0, "sat beat",  64'(beat_o[0]), 64'(m_beat[0]), 64'd0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
